// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: controller state
// encoding, state width and the bit-counter width helper.
// No ports; imported by mult_seq_ctrl and mult_seq_n.
package mult_pkg;

  localparam int ST_W = 3;

  // ST_ADD/ST_SHIFT are used by the two-phase build, ST_STEP by the fused build.
  typedef enum logic [ST_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_ADD   = 3'd1,
    ST_SHIFT = 3'd2,
    ST_STEP  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Counter must hold the value WIDTH itself, hence WIDTH+1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mult_seq_ctrl.sv
// Controller for mult_seq_n: FSM plus remaining-bit counter.
// Latency: busy/done registered; load/add_en/shift_en decoded from current state.
// Backpressure: start is only looked at in IDLE; starts while busy are dropped.
// Ports: clk, reset (sync, active-high), start, q0 (multiplier LSB) in;
//        load, add_en, shift_en (datapath strobes), busy, done out.
// Build option: MULT_FUSED_STEP_EN merges ADD and SHIFT into one STEP state.
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic q0,
  output logic load,
  output logic add_en,
  output logic shift_en,
  output logic busy,
  output logic done
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             last_bit;

  // cnt counts bits still to be processed; the shift that sees 1 is the last.
  assign last_bit = (cnt_q == CNT_W'(1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load     = 1'b0;
    add_en   = 1'b0;
    shift_en = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load  = 1'b1;
          cnt_d = CNT_W'(WIDTH);
`ifdef MULT_FUSED_STEP_EN
          state_d = ST_STEP;
`else
          state_d = ST_ADD;
`endif
        end
      end

`ifdef MULT_FUSED_STEP_EN
      ST_STEP: begin
        add_en   = q0;
        shift_en = 1'b1;
        cnt_d    = cnt_q - CNT_W'(1);
        state_d  = last_bit ? ST_DONE : ST_STEP;
      end
`else
      ST_ADD: begin
        add_en  = q0;
        state_d = ST_SHIFT;
      end

      ST_SHIFT: begin
        shift_en = 1'b1;
        cnt_d    = cnt_q - CNT_W'(1);
        state_d  = last_bit ? ST_DONE : ST_ADD;
      end
`endif

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: rtl/mult_seq_n.sv
// Sequential shift-add unsigned multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Latency: done pulses 2*WIDTH+1 cycles after the start edge (WIDTH+1 fused).
// Backpressure: start ignored while busy, no queuing; product held until next start.
// Ports: clk, reset (sync, active-high), start, multiplicand, multiplier in;
//        busy, done (1-cycle pulse), product ({A,Q}) out.
// Build option: MULT_FUSED_STEP_EN does add-if-Q[0] and shift in one cycle.
module mult_seq_n
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  logic             load, add_en, shift_en;

  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             c_q, c_d;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   ca;

  mult_seq_ctrl #(
    .WIDTH (WIDTH)
  ) u_ctrl (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .q0       (q_q[0]),
    .load     (load),
    .add_en   (add_en),
    .shift_en (shift_en),
    .busy     (busy),
    .done     (done)
  );

  // Carry out of this adder is C; the full product always fits 2*WIDTH bits.
  assign sum = {1'b0, a_q} + {1'b0, m_q};

  always_comb begin
    m_d = m_q;
    a_d = a_q;
    q_d = q_q;
    c_d = c_q;
    // Value of {C,A} entering the shift: the fresh sum when add and shift
    // share a cycle (fused step), otherwise the registered pair.
    ca  = add_en ? sum : {c_q, a_q};

    if (load) begin
      m_d = multiplicand;
      q_d = multiplier;
      a_d = '0;
      c_d = 1'b0;
    end else if (shift_en) begin
      // {C,A,Q} <= {1'b0,C,A,Q} >> 1
      c_d = 1'b0;
      a_d = ca[WIDTH:1];
      q_d = {ca[0], q_q[WIDTH-1:1]};
    end else if (add_en) begin
      {c_d, a_d} = sum;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_q <= '0;
      a_q <= '0;
      q_q <= '0;
      c_q <= 1'b0;
    end else begin
      m_q <= m_d;
      a_q <= a_d;
      q_q <= q_d;
      c_q <= c_d;
    end
  end

  assign product = {a_q, q_q};

endmodule
